id_operand_stage: RTL

- Decode/operand-fetch stage that sits directly upstream of the ALU.
- Holds the 32-entry integer register file and accepts one instruction word per valid/ready handshake.
- Resolves rs1/rs2 or the sign-extended immediate and registers operation, a, b and rd into an output stage that drives the ALU inputs.
- The write-back port updates the register file and bypasses same-cycle writes into the operand read.

---
 rtl/id_operand_stage.sv | 132 +++++++++++++
 1 files changed

// File: rtl/id_operand_stage.sv
// Decode/operand-fetch stage: 32-entry register file, rs1/rs2/immediate operand
// selection with write-back bypass, and a single registered output slot toward the ALU.
module id_operand_stage #(
  parameter int BITS = 32,
  parameter int REGS = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [31:0]     instr,
  input  logic            wb_en,
  input  logic [4:0]      wb_addr,
  input  logic [BITS-1:0] wb_data,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [31:0]     operation,
  output logic [BITS-1:0] a,
  output logic [BITS-1:0] b,
  output logic [4:0]      rd,
  output logic            illegal
);

  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;

  function automatic logic signed [BITS-1:0] sext_imm12(input logic [11:0] imm);
    return $signed({{(BITS-12){imm[11]}}, imm});
  endfunction

  logic [BITS-1:0]        rf [REGS];
  logic [4:0]             rs1_p0;
  logic [4:0]             rs2_p0;
  logic [6:0]             opcode_p0;
  logic [BITS-1:0]        rs1_val_p0;
  logic [BITS-1:0]        rs2_val_p0;
  logic signed [BITS-1:0] a_p0;
  logic signed [BITS-1:0] b_p0;
  logic                   illegal_p0;
  logic                   accept_p0;

  logic                   vld_p1;
  logic [31:0]            operation_p1;
  logic signed [BITS-1:0] a_p1;
  logic signed [BITS-1:0] b_p1;
  logic [4:0]             rd_p1;
  logic                   illegal_p1;

  // ---- stage p0: field extraction, register read with write-back bypass, decode ----
  assign rs1_p0    = instr[19:15];
  assign rs2_p0    = instr[24:20];
  assign opcode_p0 = instr[6:0];

  assign in_ready  = !vld_p1 || out_ready;
  assign accept_p0 = in_valid && in_ready;

  always_comb begin
    rs1_val_p0 = rf[rs1_p0];
    if (rs1_p0 == 5'd0) begin
      rs1_val_p0 = '0;
    end else if (wb_en && (wb_addr == rs1_p0)) begin
      rs1_val_p0 = wb_data;
    end
  end

  always_comb begin
    rs2_val_p0 = rf[rs2_p0];
    if (rs2_p0 == 5'd0) begin
      rs2_val_p0 = '0;
    end else if (wb_en && (wb_addr == rs2_p0)) begin
      rs2_val_p0 = wb_data;
    end
  end

  always_comb begin
    a_p0       = '0;
    b_p0       = '0;
    illegal_p0 = 1'b0;
    unique case (opcode_p0)
      OPC_OP: begin
        a_p0 = $signed(rs1_val_p0);
        b_p0 = $signed(rs2_val_p0);
      end
      OPC_OP_IMM: begin
        // Shift-immediates take the same path; the ALU only looks at b[4:0].
        a_p0 = $signed(rs1_val_p0);
        b_p0 = sext_imm12(instr[31:20]);
      end
      default: illegal_p0 = 1'b1;
    endcase
  end

  // x0 is never stored, so reads of it can rely on the explicit zero above.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < REGS; i++) begin
        rf[i] <= '0;
      end
    end else if (wb_en && (wb_addr != 5'd0)) begin
      rf[wb_addr] <= wb_data;
    end
  end

  // ---- stage p1: output slot driving the ALU; holds while stalled ----
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_p1       <= 1'b0;
      operation_p1 <= '0;
      a_p1         <= '0;
      b_p1         <= '0;
      rd_p1        <= '0;
      illegal_p1   <= 1'b0;
    end else if (accept_p0) begin
      vld_p1       <= 1'b1;
      operation_p1 <= instr;
      a_p1         <= a_p0;
      b_p1         <= b_p0;
      rd_p1        <= instr[11:7];
      illegal_p1   <= illegal_p0;
    end else if (out_ready) begin
      vld_p1       <= 1'b0;
    end
  end

  assign out_valid = vld_p1;
  assign operation = operation_p1;
  assign a         = a_p1;
  assign b         = b_p1;
  assign rd        = rd_p1;
  assign illegal   = illegal_p1;

endmodule
